uart_tx_reg_fifo_encoder: RTL and testbench

Parametrised successor to the UART TX register encoder. Unpacks a bus-written TX register word into data, parity-enable and parity-odd fields, and buffers entries in a DEPTH-deep FIFO. Presents the FIFO head to the UART transmitter over a valid/ready handshake, so the CPU can queue several characters without polling between writes. Sits between the memory-mapped UART TX register and the Tx shift/parity logic.

---
 rtl/uart_tx_reg_fifo_encoder_if.sv | 27 ++
 rtl/uart_tx_reg_fifo_encoder.sv | 127 ++++++++++++
 tb/tb_uart_tx_reg_fifo_encoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_reg_fifo_encoder_if.sv
// Handshake bundle for uart_tx_reg_fifo_encoder.
// master: environment side (CPU register write strobe plus transmitter ready).
// slave : the encoder FIFO itself.
interface uart_tx_reg_fifo_encoder_if #(
  parameter int REG_W  = 32,
  parameter int DATA_W = 8
) ();

  logic [REG_W-1:0]  uart_tx_reg_in;
  logic              tx_wr;
  logic [DATA_W-1:0] tx_data;
  logic              parity_en;
  logic              parity_odd;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output uart_tx_reg_in, tx_wr, tx_ready,
    input  tx_data, parity_en, parity_odd, tx_valid
  );

  modport slave (
    input  uart_tx_reg_in, tx_wr, tx_ready,
    output tx_data, parity_en, parity_odd, tx_valid
  );

endinterface

// File: rtl/uart_tx_reg_fifo_encoder.sv
// UART TX register encoder with a DEPTH-deep show-ahead FIFO.
// Unpacks {parity_odd, parity_en, data} from the written register word,
// queues it, and presents the head entry over a valid/ready handshake.
// Optional build macro UART_TX_OVF_STICKY_EN: overflow becomes a sticky flag
// cleared by reset or by a write with bit [REG_W-1] set; otherwise overflow
// is a one-cycle pulse on each dropped write.
module uart_tx_reg_fifo_encoder #(
  parameter int REG_W  = 32,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_reg_fifo_encoder_if.slave bus,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  typedef struct packed {
    logic              parity_odd;
    logic              parity_en;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t             wr_entry;
  entry_t             head;
  logic               push;
  logic               pop;
  logic               drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_count = count_q;

  // Handshake decode: a write into a full FIFO still lands if the head leaves.
  always_comb begin
    wr_entry = entry_t'(bus.uart_tx_reg_in[ENT_W-1:0]);
    pop      = !fifo_empty && bus.tx_ready;
    push     = bus.tx_wr && (!fifo_full || pop);
    drop     = bus.tx_wr && fifo_full && !pop;
  end

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; a strobe during the reset cycle is ignored.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; contents are only visible once count says valid.
    if (push && !rst) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Show-ahead head presentation.
  always_comb begin
    head           = mem_q[rd_ptr_q];
    bus.tx_data    = head.data;
    bus.parity_en  = head.parity_en;
    bus.parity_odd = head.parity_odd;
    bus.tx_valid   = !fifo_empty;
  end

`ifdef UART_TX_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a dropped write wins over a clearing write.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)                                          ovf_d = 1'b1;
    else if (bus.tx_wr && bus.uart_tx_reg_in[REG_W-1]) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = drop;
`endif

  // Register bits above the entry fields carry no FIFO payload.
  generate
    if (REG_W > ENT_W) begin : g_unused_upper
      logic unused_upper_bits;
      assign unused_upper_bits = ^bus.uart_tx_reg_in[REG_W-1:ENT_W];
    end
  endgenerate

endmodule

// File: tb/tb_uart_tx_reg_fifo_encoder.sv
// Self-checking bench for uart_tx_reg_fifo_encoder (REG_W=32, DATA_W=8, DEPTH=4).
// Accepted writes are pushed to a scoreboard queue; the head is compared with the
// queue front every cycle and popped when the handshake completes.
module tb_uart_tx_reg_fifo_encoder;

  localparam int REG_W  = 32;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int ENT_W  = DATA_W + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  uart_tx_reg_fifo_encoder_if #(.REG_W(REG_W), .DATA_W(DATA_W)) bus ();

  uart_tx_reg_fifo_encoder #(
    .REG_W (REG_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  logic [ENT_W-1:0] sb [$];
  logic             ovf_m;
  int               n_vec = 0;
  int               n_err = 0;

  function automatic logic [ENT_W-1:0] head_now();
    return {bus.parity_odd, bus.parity_en, bus.tx_data};
  endfunction

  // One clock cycle: drive inputs, compare against the model, advance model.
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic drive_cycle(input logic wr, input logic [REG_W-1:0] word,
                             input logic rdy, input string tag);
    logic             full_m, pop_m, push_m, drop_m;
    logic [ENT_W-1:0] exp;
    bus.tx_wr          = wr;
    bus.uart_tx_reg_in = word;
    bus.tx_ready       = rdy;
    #1;
    full_m = (sb.size() == DEPTH);
    pop_m  = (sb.size() != 0) && rdy;
    push_m = wr && (!full_m || pop_m);
    drop_m = wr && full_m && !pop_m;
    n_vec++;
    if (bus.tx_valid !== (sb.size() != 0)) begin
      n_err++;
      $display("FAIL %s tx_valid: got %b want %b", tag, bus.tx_valid, sb.size() != 0);
    end
    n_vec++;
    if (fifo_count !== CNT_W'(sb.size())) begin
      n_err++;
      $display("FAIL %s fifo_count: got %0d want %0d", tag, fifo_count, sb.size());
    end
    if (sb.size() != 0) begin
      exp = sb[0];
      n_vec++;
      if (head_now() !== exp) begin
        n_err++;
        $display("FAIL %s head {odd,en,data}: got %h want %h", tag, head_now(), exp);
      end
    end
`ifdef UART_TX_OVF_STICKY_EN
    n_vec++;
    if (overflow !== ovf_m) begin
      n_err++;
      $display("FAIL %s overflow(sticky): got %b want %b", tag, overflow, ovf_m);
    end
    if (drop_m)                       ovf_m = 1'b1;
    else if (wr && word[REG_W-1])     ovf_m = 1'b0;
`else
    n_vec++;
    if (overflow !== drop_m) begin
      n_err++;
      $display("FAIL %s overflow(pulse): got %b want %b", tag, overflow, drop_m);
    end
`endif
    if (pop_m)  exp = sb.pop_front();
    if (push_m) sb.push_back(word[ENT_W-1:0]);
    @(negedge clk);
    bus.tx_wr    = 1'b0;
    bus.tx_ready = 1'b0;
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1 && sb.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1, tag);
    n_vec++;
    if (fifo_empty !== 1'b1) begin
      n_err++;
      $display("FAIL %s drained fifo_empty: got %b want 1", tag, fifo_empty);
    end
  endtask

  // Reset pulse with a write strobe that must be ignored.
  task automatic pulse_reset(input string tag);
    rst                = 1'b1;
    bus.tx_wr          = 1'b1;
    bus.uart_tx_reg_in = 32'h0000_0099;
    @(negedge clk);
    rst       = 1'b0;
    bus.tx_wr = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    #1;
    n_vec++;
    if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL %s tx_valid: got %b want 0", tag, bus.tx_valid); end
    n_vec++;
    if (fifo_count !== '0) begin n_err++; $display("FAIL %s fifo_count: got %0d want 0", tag, fifo_count); end
    n_vec++;
    if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL %s fifo_empty: got %b want 1", tag, fifo_empty); end
    n_vec++;
    if (fifo_full !== 1'b0) begin n_err++; $display("FAIL %s fifo_full: got %b want 0", tag, fifo_full); end
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL %s overflow: got %b want 0", tag, overflow); end
  endtask

  task automatic test_reset();
    pulse_reset("reset");
    drive_cycle(1'b0, '0, 1'b1, "reset_idle");
  endtask

  task automatic test_single_write();
    drive_cycle(1'b1, 32'h0000_00A5, 1'b0, "single_wr");
    n_vec++;
    if (bus.tx_valid !== 1'b1) begin n_err++; $display("FAIL single latency tx_valid: got %b want 1", bus.tx_valid); end
    n_vec++;
    if (bus.tx_data !== 8'hA5) begin n_err++; $display("FAIL single tx_data: got %h want a5", bus.tx_data); end
    n_vec++;
    if ({bus.parity_odd, bus.parity_en} !== 2'b00) begin
      n_err++; $display("FAIL single parity {odd,en}: got %b want 00", {bus.parity_odd, bus.parity_en});
    end
    n_vec++;
    if (fifo_count !== CNT_W'(1)) begin n_err++; $display("FAIL single fifo_count: got %0d want 1", fifo_count); end
    drive_cycle(1'b0, '0, 1'b1, "single_pop");
    n_vec++;
    if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL single fifo_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_parity_fields();
    logic [REG_W-1:0] words [3] = '{32'h141, 32'h342, 32'h043};
    logic [ENT_W-1:0] exp   [3] = '{{1'b0, 1'b1, 8'h41}, {1'b1, 1'b1, 8'h42}, {1'b0, 1'b0, 8'h43}};
    foreach (words[i]) drive_cycle(1'b1, words[i], 1'b0, "parity_wr");
    n_vec++;
    if (fifo_count !== CNT_W'(3)) begin n_err++; $display("FAIL parity fifo_count: got %0d want 3", fifo_count); end
    foreach (exp[i]) begin
      n_vec++;
      if (head_now() !== exp[i]) begin
        n_err++; $display("FAIL parity drain[%0d]: got %h want %h", i, head_now(), exp[i]);
      end
      drive_cycle(1'b0, '0, 1'b1, "parity_pop");
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) drive_cycle(1'b1, REG_W'(i), 1'b0, "ovf_wr");
    n_vec++;
    if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovf fifo_full: got %b want 1", fifo_full); end
    n_vec++;
    if (fifo_count !== CNT_W'(DEPTH)) begin n_err++; $display("FAIL ovf fifo_count: got %0d want %0d", fifo_count, DEPTH); end
`ifdef UART_TX_OVF_STICKY_EN
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf sticky held: got %b want 1", overflow); end
`endif
    drain("ovf_drain");
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 32'h11 + REG_W'(i), 1'b0, "fpp_fill");
    drive_cycle(1'b1, 32'h0000_0015, 1'b1, "fpp_both");
    n_vec++;
    if (fifo_count !== CNT_W'(DEPTH)) begin n_err++; $display("FAIL fpp fifo_count: got %0d want %0d", fifo_count, DEPTH); end
    n_vec++;
    if (bus.tx_data !== 8'h12) begin n_err++; $display("FAIL fpp head advanced: got %h want 12", bus.tx_data); end
    drain("fpp_drain");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 32'h60 + REG_W'(i), 1'b1, "b2b_stream");
      n_vec++;
      if (fifo_count > CNT_W'(1)) begin n_err++; $display("FAIL b2b fifo_count: got %0d want <=1", fifo_count); end
    end
    drain("b2b_drain");
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 32'h70 + REG_W'(i), 1'b0, "wrap_wr");
    drain("wrap_drain");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b1, 32'h21 + REG_W'(i), 1'b0, "mid_fill");
    drive_cycle(1'b0, '0, 1'b1, "mid_pop1");
    n_vec++;
    if (fifo_count !== CNT_W'(3)) begin n_err++; $display("FAIL mid pre-reset count: got %0d want 3", fifo_count); end
    pulse_reset("mid_reset");
    drive_cycle(1'b1, 32'h0000_007E, 1'b0, "mid_wr7e");
    n_vec++;
    if (fifo_count !== CNT_W'(1) || bus.tx_data !== 8'h7E) begin
      n_err++; $display("FAIL mid single 7e: got count %0d data %h want 1 7e", fifo_count, bus.tx_data);
    end
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 32'h31 + REG_W'(i), 1'b0, "mid_refill");
    drive_cycle(1'b1, 32'h8000_007E, 1'b0, "mid_clr_dropped");
`ifdef UART_TX_OVF_STICKY_EN
    n_vec++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL mid dropped clear: got %b want 1", overflow); end
`endif
    drive_cycle(1'b1, 32'h8000_007E, 1'b1, "mid_clr_accepted");
`ifdef UART_TX_OVF_STICKY_EN
    n_vec++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL mid accepted clear: got %b want 0", overflow); end
`endif
    drain("mid_drain");
  endtask

  initial begin
    rst                = 1'b1;
    bus.tx_wr          = 1'b0;
    bus.tx_ready       = 1'b0;
    bus.uart_tx_reg_in = '0;
    ovf_m              = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    test_reset();
    test_single_write();
    test_parity_fields();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
